fft4_stream_out: RTL and testbench
==================================

# fft4_stream_out

Output serializer for the 4-point DIT FFT. It accepts one complete transform result per frame: four complex bins, presented as eight parallel signed words from the final pipeline register stage. It then streams the bins out one complex sample per cycle, in natural order X0..X3, over a valid/ready interface. It sits between the FFT core's output register and downstream consumers such as a memory writer or a magnitude unit.

## Interface
- `N`, default 35: width of each input real/imag word (two's complement).
- `SHIFT`, default 0: arithmetic right shift applied to every output word; legal range 0..4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (rst=0 resets).
- `in_valid`  in  1  frame present on inputs.
- `in_ready`  out  1  block can capture a frame this cycle.
- `x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im`  in  N each, signed  FFT bins X0..X3.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts sample.
- `out_re, out_im`  out  N-SHIFT each, signed  current bin.
- `out_idx`  out  2  bin index of current sample.
- `out_last`  out  1  high with bin 3.

## Operation
- Frame capture:
  - On an edge where in_valid && in_ready, all eight words are stored in a frame buffer.
  - Input values on other edges are ignored.
- FSM with two states, IDLE and SEND.
  - IDLE: in_ready=1, out_valid=0. A capture moves the FSM to SEND with idx=0.
  - SEND: out_valid=1. out_re/out_im hold bin[idx], shifted.
    - out_valid && out_ready with idx<3: idx increments.
    - Same condition with idx==3: the sample is the last of the frame.
      - If in_valid is also high, the new frame is captured on that same edge, idx=0, and the FSM stays in SEND.
      - Otherwise the FSM returns to IDLE.
- `in_ready` is combinational: (state==IDLE) || (state==SEND && idx==3 && out_ready). It is forced to 0 while rst=0.
- Backpressure: while out_valid && !out_ready, out_re, out_im, out_idx and out_last hold stable. The frame buffer is not overwritten.
- Arithmetic:
  - out = word >>> SHIFT (floor, sign-extended), taking the low N-SHIFT bits.
  - This is exact because the shifted result always fits in N-SHIFT bits. No rounding, no saturation.
- `out_last` = out_valid && idx==3.
- A frame captured while out_ready is held low is never dropped. Samples are emitted only as they are accepted.

## Timing
- Reset (rst=0, asynchronous):
  - State=IDLE, idx=0, frame buffer=0.
  - out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, in_ready=0.
- After rst rises: in_ready=1 in the first cycle.
- Latency: a frame captured at edge k gives X0 on the outputs (out_valid=1) from edge k+1.
- With out_ready=1 and a continuous in_valid stream:
  - X0..X3 are accepted at edges k+1..k+4.
  - The next frame is captured at edge k+4.
  - Throughput is 1 sample per cycle, 4 cycles per frame, with no bubble.
- Outputs are registered, with no combinational path from out_ready to out_re/out_im. in_ready does depend combinationally on out_ready.
- Reset mid-frame: the remaining samples are discarded, outputs go to 0 immediately, and no partial frame is resumed.

## Test plan
- Reset values:
  - Stimulus: assert rst=0 mid-SEND.
  - Required: all outputs 0 at once. After release, in_ready=1 and out_valid=0 until a capture.
- Single frame, out_ready=1:
  - Stimulus: X=(10,-1),(2,3),(-7,0),(4,-5).
  - Required: the four bins appear on consecutive cycles starting one cycle after capture, with out_idx 0,1,2,3 and out_last only on bin 3. Then out_valid=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles while bin 1 is presented.
  - Required: bin 1 held stable, in_ready=0, and a new in_valid frame is not captured. The sequence resumes with bin 2 after release.
- Back-to-back frames:
  - Stimulus: in_valid=1 continuously, two frames.
  - Required: 8 consecutive valid samples with no gap, and the second frame is captured on the edge where bin 3 of the first is accepted.
- Sign/shift (SHIFT=2, N=35):
  - Stimulus: input -5 and input 2^34-1.
  - Required: outputs -2 and 2^32-1 respectively (33-bit signed).
- Extremes (SHIFT=0):
  - Stimulus: inputs -2^34 and 2^34-1.
  - Required: passed through bit-exact.

Source files
------------

// File: rtl/fft4_stream_out.sv
// Output serializer for the 4-point FFT: captures one frame of four complex bins
// and streams them X0..X3 over a valid/ready interface with an optional arithmetic shift.
//
//   state | meaning
//   IDLE  | no frame held, ready to capture
//   SEND  | presenting bin[idx] until accepted
module fft4_stream_out #(
    parameter int N     = 35,
    parameter int SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [N-1:0]        x0_re,
    input  logic signed [N-1:0]        x0_im,
    input  logic signed [N-1:0]        x1_re,
    input  logic signed [N-1:0]        x1_im,
    input  logic signed [N-1:0]        x2_re,
    input  logic signed [N-1:0]        x2_im,
    input  logic signed [N-1:0]        x3_re,
    input  logic signed [N-1:0]        x3_im,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [N-SHIFT-1:0]  out_re,
    output logic signed [N-SHIFT-1:0]  out_im,
    output logic [1:0]                 out_idx,
    output logic                       out_last
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [1:0]         idx, idx_nxt;
    logic signed [N-1:0] frame_re [4];
    logic signed [N-1:0] frame_im [4];
    logic               capture;
    logic               accept;
    logic signed [N-1:0] sel_re, sel_im, shf_re, shf_im;

    assign capture = in_valid && in_ready;
    assign accept  = (state == SEND) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Frame buffer only loads on a handshake, so backpressure can never corrupt it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                frame_re[i] <= '0;
                frame_im[i] <= '0;
            end
        end else if (capture) begin
            frame_re[0] <= x0_re;
            frame_im[0] <= x0_im;
            frame_re[1] <= x1_re;
            frame_im[1] <= x1_im;
            frame_re[2] <= x2_re;
            frame_im[2] <= x2_im;
            frame_re[3] <= x3_re;
            frame_im[3] <= x3_im;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = SEND;
                    idx_nxt   = 2'd0;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx != 2'd3) begin
                        idx_nxt = idx + 2'd1;
                    end else begin
                        idx_nxt   = 2'd0;
                        state_nxt = capture ? SEND : IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 2'd0;
            end
        endcase
    end

    // Output words come straight from registers; only in_ready sees out_ready.
    always_comb begin
        in_ready  = rst && ((state == IDLE) ||
                            ((state == SEND) && (idx == 2'd3) && out_ready));
        out_valid = (state == SEND);
        out_idx   = idx;
        out_last  = (state == SEND) && (idx == 2'd3);
        sel_re    = frame_re[idx];
        sel_im    = frame_im[idx];
        shf_re    = sel_re >>> SHIFT;
        shf_im    = sel_im >>> SHIFT;
        out_re    = shf_re[N-SHIFT-1:0];
        out_im    = shf_im[N-SHIFT-1:0];
    end

endmodule

// File: tb/tb_fft4_stream_out.sv
// Scoreboard bench for fft4_stream_out: a SHIFT=0 and a SHIFT=2 instance share
// stimulus; captured frames push expected samples, a monitor pops on each accept.
module tb_fft4_stream_out;
    localparam int N = 35;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                in_valid, out_ready;
    logic signed [N-1:0] x [8];

    logic                in_ready, out_valid, out_last;
    logic signed [N-1:0] out_re, out_im;
    logic [1:0]          out_idx;

    logic                in_ready2, out_valid2, out_last2;
    logic signed [N-3:0] out_re2, out_im2;
    logic [1:0]          out_idx2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [N-1:0] re;
        logic signed [N-1:0] im;
        logic signed [N-3:0] re2;
        logic signed [N-3:0] im2;
        logic [1:0]          idx;
        logic                last;
    } exp_t;

    exp_t q[$];

    fft4_stream_out #(.N(N), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x0_re(x[0]), .x0_im(x[1]), .x1_re(x[2]), .x1_im(x[3]),
        .x2_re(x[4]), .x2_im(x[5]), .x3_re(x[6]), .x3_im(x[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
    );

    fft4_stream_out #(.N(N), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .x0_re(x[0]), .x0_im(x[1]), .x1_re(x[2]), .x1_im(x[3]),
        .x2_re(x[4]), .x2_im(x[5]), .x3_re(x[6]), .x3_im(x[7]),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_re(out_re2), .out_im(out_im2), .out_idx(out_idx2), .out_last(out_last2)
    );

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        exp_t                e;
        logic signed [N-1:0] t;
        for (int b = 0; b < 4; b++) begin
            e.re   = x[2*b];
            e.im   = x[2*b+1];
            t      = x[2*b] >>> 2;
            e.re2  = t[N-3:0];
            t      = x[2*b+1] >>> 2;
            e.im2  = t[N-3:0];
            e.idx  = 2'(b);
            e.last = (b == 3);
            q.push_back(e);
        end
    endtask

    // Monitor: compare every accepted sample against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_sample", out_idx, -1);
            end else begin
                e = q.pop_front();
                chk("out_re",    out_re,     e.re);
                chk("out_im",    out_im,     e.im);
                chk("out_idx",   out_idx,    e.idx);
                chk("out_last",  out_last,   e.last);
                chk("out_re_s2", out_re2,    e.re2);
                chk("out_im_s2", out_im2,    e.im2);
                chk("valid_s2",  out_valid2, 1);
            end
        end
    end

    // Present a frame and hold it until captured; returns 1 ns after the capture edge.
    task automatic send(input longint a0, a1, a2, a3, a4, a5, a6, a7);
        bit done;
        x[0] = a0[N-1:0]; x[1] = a1[N-1:0]; x[2] = a2[N-1:0]; x[3] = a3[N-1:0];
        x[4] = a4[N-1:0]; x[5] = a5[N-1:0]; x[6] = a6[N-1:0]; x[7] = a7[N-1:0];
        in_valid = 1'b1;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_frame();
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("capture_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic expect_run(input int n, input bit b2b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("run_valid", out_valid, 1);
            chk("run_idx",   out_idx,   i % 4);
            if (b2b && i == 3) chk("b2b_in_ready_on_last", in_ready, 1);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) done = 1;
        end
        chk("drain", done, 1);
    endtask

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) x[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_re",    out_re,    0);
        chk("rst_out_im",    out_im,    0);
        chk("rst_out_idx",   out_idx,   0);
        chk("rst_out_last",  out_last,  0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready",  in_ready,  1);
        chk("post_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Single frame
        send(10, -1, 2, 3, -7, 0, 4, -5);
        expect_run(4, 0);
        @(negedge clk);
        chk("idle_after_frame", out_valid, 0);
        wait_drain();
        @(posedge clk);
        #1;

        // Backpressure on bin 1 with a competing frame offered
        send(100, -100, -33, 77, 5, -6, 0, 1);
        @(negedge clk);
        chk("bp_bin0_idx", out_idx, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) x[i] = 35'sd999;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_idx",      out_idx,  1);
            chk("bp_re",       out_re,   -33);
            chk("bp_im",       out_im,   77);
            chk("bp_valid",    out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idx", out_idx, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_resume_idx", out_idx, 2);
        wait_drain();
        @(posedge clk);
        #1;

        // Back-to-back frames
        send(1, 2, 3, 4, 5, 6, 7, 8);
        fork
            send(-1, -2, -3, -4, -5, -6, -7, -8);
            expect_run(8, 1);
        join
        @(negedge clk);
        chk("b2b_idle_after", out_valid, 0);
        wait_drain();
        @(posedge clk);
        #1;

        // Sign/shift and extremes
        send(-5, 64'sd17179869183, -64'sd17179869184, 64'sd17179869183, 0, -1, 7, -8);
        @(negedge clk);
        chk("shift_neg5",    out_re2, -2);
        chk("shift_max",     out_im2, 64'sd4294967295);
        chk("pass_neg5",     out_re,  -5);
        chk("pass_max_bin0", out_im,  64'sd17179869183);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pass_min",   out_re,  -64'sd17179869184);
        chk("pass_max",   out_im,  64'sd17179869183);
        chk("shift_min",  out_re2, -64'sd4294967296);
        wait_drain();
        @(posedge clk);
        #1;

        // Reset mid-frame
        send(11, 12, 13, 14, 15, 16, 17, 18);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid",    out_valid,  0);
        chk("mid_rst_re",       out_re,     0);
        chk("mid_rst_im",       out_im,     0);
        chk("mid_rst_idx",      out_idx,    0);
        chk("mid_rst_last",     out_last,   0);
        chk("mid_rst_in_ready", in_ready,   0);
        chk("mid_rst_re_s2",    out_re2,    0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("after_rst_in_ready",  in_ready,  1);
            chk("after_rst_out_valid", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
